// File: rtl/alu_dispatch.sv
// alu_dispatch: buffers ALU commands in a FIFO, issues one at a time, waits out the ALU latency
// and holds each result for a valid/ready consumer. Optional macro: ALU_DISPATCH_ILLEGAL_OP_CHECK_EN.
module alu_dispatch #(
   parameter int FIFO_DEPTH  = 4,
   parameter int ALU_LATENCY = 1
) (
   input  logic       clock_in,
   input  logic       reset_in,
   input  logic       cmd_valid_in,
   output logic       cmd_ready_out,
   input  logic [2:0] cmd_opcode_in,
   input  logic [7:0] cmd_a_in,
   input  logic [7:0] cmd_b_in,
   output logic       alu_enable_out,
   output logic [2:0] alu_opcode_out,
   output logic [7:0] alu_input1_out,
   output logic [7:0] alu_input2_out,
   input  logic [7:0] alu_output_in,
   output logic       res_valid_out,
   input  logic       res_ready_in,
   output logic [7:0] res_data_out,
   output logic [2:0] res_opcode_out,
   output logic       busy_out,
   output logic       illegal_op_out
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);
   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
   state_t state_q, state_d;
   logic [18:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [PW:0] count_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic alu_en_q, alu_en_d, res_valid_q, res_valid_d, illegal_q, illegal_d;
   logic [2:0] alu_op_q, alu_op_d, res_op_q, res_op_d;
   logic [7:0] a_q, a_d, b_q, b_d, res_data_q, res_data_d;
   logic [18:0] head;
   logic push, pop, issue, head_bad;

   assign head = mem_q[rd_q];
   // ready is forced low while reset is held, even though the count already reads empty
   assign cmd_ready_out = reset_in && (count_q != (PW+1)'(FIFO_DEPTH));
   assign push = cmd_valid_in && cmd_ready_out;
   assign pop = (count_q != '0) && ((state_q == IDLE) || ((state_q == HOLD) && res_ready_in));
`ifdef ALU_DISPATCH_ILLEGAL_OP_CHECK_EN
   assign head_bad = head[18:16] > 3'b100;
`else
   assign head_bad = 1'b0;
`endif
   assign issue = pop && !head_bad;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_en_d    = alu_en_q;
      alu_op_d    = alu_op_q;
      a_d         = a_q;
      b_d         = b_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_op_d    = res_op_q;
      illegal_d   = pop && head_bad;
      if (state_q == WAIT) begin
         if (cnt_q == '0) begin
            state_d     = HOLD;
            alu_en_d    = 1'b0;
            res_valid_d = 1'b1;
            res_data_d  = alu_output_in;
            res_op_d    = alu_op_q;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
      if ((state_q == HOLD) && res_ready_in) begin
         res_valid_d = 1'b0;
         state_d     = IDLE;
      end
      // a pop from IDLE or on the HOLD handshake edge both start the next command here
      if (issue) begin
         state_d                   = WAIT;
         alu_en_d                  = 1'b1;
         {alu_op_d, a_d, b_d}      = head;
         cnt_d                     = CW'(ALU_LATENCY);
      end
   end

   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         state_q     <= IDLE;
         wr_q        <= '0;
         rd_q        <= '0;
         count_q     <= '0;
         cnt_q       <= '0;
         alu_en_q    <= 1'b0;
         alu_op_q    <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_op_q    <= '0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_q + PW'(push);
         rd_q        <= rd_q + PW'(pop);
         count_q     <= count_q + (PW+1)'(push) - (PW+1)'(pop);
         cnt_q       <= cnt_d;
         alu_en_q    <= alu_en_d;
         alu_op_q    <= alu_op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_op_q    <= res_op_d;
         illegal_q   <= illegal_d;
      end
   end

   always_ff @(posedge clock_in) begin
      if (push) mem_q[wr_q] <= {cmd_opcode_in, cmd_a_in, cmd_b_in};
   end

   assign alu_enable_out = alu_en_q;
   assign alu_opcode_out = alu_op_q;
   assign alu_input1_out = a_q;
   assign alu_input2_out = b_q;
   assign res_valid_out  = res_valid_q;
   assign res_data_out   = res_data_q;
   assign res_opcode_out = res_op_q;
   assign busy_out       = (count_q != '0) || (state_q != IDLE);
   assign illegal_op_out = illegal_q;
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: directed scoreboard bench for alu_dispatch with a 1-cycle ALU stand-in.
module tb_alu_dispatch;
   logic clk = 1'b0, rst_n = 1'b0;
   logic cmd_valid = 1'b0, cmd_ready;
   logic [2:0] cmd_op = '0;
   logic [7:0] cmd_a = '0, cmd_b = '0;
   logic alu_en, res_valid, res_ready = 1'b0, busy, illegal;
   logic [2:0] alu_op, res_op;
   logic [7:0] alu_a, alu_b, alu_out = '0, res_data;
   int vectors = 0, errs = 0, res_cnt = 0, ill_cnt = 0;
   logic [10:0] exp_q[$];

   always #5 clk = ~clk;

   alu_dispatch #(.FIFO_DEPTH(4), .ALU_LATENCY(1)) dut (
      .clock_in(clk), .reset_in(rst_n),
      .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready),
      .cmd_opcode_in(cmd_op), .cmd_a_in(cmd_a), .cmd_b_in(cmd_b),
      .alu_enable_out(alu_en), .alu_opcode_out(alu_op),
      .alu_input1_out(alu_a), .alu_input2_out(alu_b), .alu_output_in(alu_out),
      .res_valid_out(res_valid), .res_ready_in(res_ready),
      .res_data_out(res_data), .res_opcode_out(res_op),
      .busy_out(busy), .illegal_op_out(illegal)
   );

   function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a * b;
         3'd3: return {7'b0, a == b};
         3'd4: return {7'b0, a > b};
         default: return 8'h00;
      endcase
   endfunction

   // ALU stand-in: samples inputs one edge after issue, result valid after that edge
   always @(posedge clk) if (alu_en) alu_out <= alu_f(alu_op, alu_a, alu_b);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (illegal) ill_cnt++;
      if (rst_n && res_valid && res_ready) begin
         res_cnt++;
         if (exp_q.size() == 0) begin
            vectors++;
            errs++;
            $display("FAIL unexpected result: got op %0h data %0h expected none", res_op, res_data);
         end else begin
            chk("result", {21'b0, res_op, res_data}, {21'b0, exp_q.pop_front()});
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit exp_en, input logic [7:0] d);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            if (exp_en) exp_q.push_back({op, d});
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            return;
         end
      end
      cmd_valid = 1'b0;
      chk("push timeout", 0, 1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy && !res_valid) begin step(1); return; end
      end
      chk("idle timeout", 0, 1);
   endtask

   initial begin
      int n, r0, i0;
      repeat (3) @(negedge clk);
      chk("reset ctl", {27'b0, cmd_ready, busy, alu_en, res_valid, illegal}, 0);
      chk("reset data", {2'b0, alu_op, alu_a, alu_b, res_data, res_op}, 0);
      @(posedge clk); #1; rst_n = 1'b1; #1;
      chk("ready after reset", cmd_ready, 1);

      res_ready = 1'b1;
      push(3'd0, 8'd200, 8'd100, 1'b1, 8'h2C);
      for (int i = 0; i < 20; i++) begin @(negedge clk); if (alu_en) break; end
      n = 0;
      for (int i = 0; i < 20; i++) begin @(negedge clk); n++; if (res_valid) break; end
      chk("add issue-to-valid edges", n, 2);
      wait_idle();

      res_ready = 1'b0;
      r0 = res_cnt;
      push(3'd1, 8'd5, 8'd10, 1'b1, 8'hFB);
      push(3'd2, 8'd16, 8'd17, 1'b1, 8'h10);
      push(3'd3, 8'd7, 8'd7, 1'b1, 8'h01);
      push(3'd4, 8'd3, 8'd9, 1'b1, 8'h00);
      push(3'd0, 8'd255, 8'd1, 1'b1, 8'h00);
      chk("ready when full", cmd_ready, 0);
      chk("busy when full", busy, 1);
      cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 8'd9; cmd_b = 8'd9;
      n = 0;
      repeat (5) begin @(negedge clk); if (cmd_ready) n++; end
      chk("6th push stalls", n, 0);
      @(posedge clk); #1; cmd_valid = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("hold stable", {19'b0, res_valid, res_op, res_data, alu_en}, {19'b0, 1'b1, 3'd1, 8'hFB, 1'b0});
      end
      @(posedge clk); #1; res_ready = 1'b1;
      wait_idle();
      chk("fill result count", res_cnt - r0, 5);

      r0 = res_cnt; i0 = ill_cnt;
`ifdef ALU_DISPATCH_ILLEGAL_OP_CHECK_EN
      push(3'd6, 8'd4, 8'd5, 1'b0, 8'h00);
      push(3'd0, 8'd1, 8'd2, 1'b1, 8'h03);
      wait_idle();
      chk("illegal pulses", ill_cnt - i0, 1);
      chk("illegal result count", res_cnt - r0, 1);
`else
      push(3'd6, 8'd4, 8'd5, 1'b1, 8'h00);
      push(3'd0, 8'd1, 8'd2, 1'b1, 8'h03);
      wait_idle();
      chk("illegal pulses", ill_cnt - i0, 0);
      chk("opcode 6 result count", res_cnt - r0, 2);
`endif

      r0 = res_cnt;
      push(3'd2, 8'd16, 8'd17, 1'b0, 8'h00);
      push(3'd2, 8'd16, 8'd17, 1'b0, 8'h00);
      @(negedge clk);
      chk("in WAIT before reset", alu_en, 1);
      rst_n = 1'b0; #1;
      chk("reset res_valid", res_valid, 0);
      chk("reset empties fifo", busy, 0);
      chk("ready low in reset", cmd_ready, 0);
      chk("alu_enable low in reset", alu_en, 0);
      step(2);
      rst_n = 1'b1;
      n = 0;
      repeat (10) begin @(negedge clk); if (res_valid) n++; end
      chk("no result after reset", n + res_cnt - r0, 0);
      chk("scoreboard drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule
